// File: rtl/iob_fifo_stream_reader_pkg.sv
// Shared constants for the FIFO stream reader: occupancy width and prefetch buffer limits.
package iob_fifo_stream_reader_pkg;

  localparam int OCC_W         = 3;
  localparam int MAX_BUF_DEPTH = 4;
  localparam int PTR_W         = $clog2(MAX_BUF_DEPTH);

endpackage

// File: rtl/iob_fifo_stream_reader_if.sv
// FIFO read port and output stream bundled together; master is the reader, slave is FIFO plus consumer.
interface iob_fifo_stream_reader_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic              fifo_read_en;
  logic [DATA_W-1:0] fifo_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_read_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_read_en, m_valid, m_data
  );
endinterface

// File: rtl/iob_fifo_stream_reader_buf.sv
// Prefetch ring buffer: BUF_DEPTH registers with head/tail pointers, push, pop, clear and occupancy.
module iob_fifo_stream_reader_buf
  import iob_fifo_stream_reader_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occupancy,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Clear dominates: a push or pop coinciding with clear is discarded.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clear) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      if (push && !clear) mem_q[tail_q] <= push_data;
    end
  end

  assign occupancy = occ_q;
  assign head_data = mem_q[head_q];

endmodule

// File: rtl/iob_fifo_stream_reader.sv
// Read-domain drain engine: strobes a registered-output FIFO and re-presents words as a valid/ready stream.
module iob_fifo_stream_reader
  import iob_fifo_stream_reader_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int BUF_DEPTH = 3   // 2..4; 3 or more sustains one word per cycle
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        fifo_level,
  iob_fifo_stream_reader_if.master bus,
  output logic [OCC_W-1:0]         occupancy,
  output logic [ADDR_W-1:0]        fifo_level_o
);

  logic              inflight_q, inflight_d;
  logic              drop_next_q, drop_next_d;
  logic [ADDR_W-1:0] level_q, level_d;
  logic [ADDR_W:0]   level_sum;
  logic [OCC_W:0]    pending;
  logic              push, pop;

  // Issue decision uses registered counts only, so m_ready never reaches the strobe.
  assign pending          = {1'b0, occupancy} + {{OCC_W{1'b0}}, inflight_q};
  assign bus.fifo_read_en = !rst && !bus.fifo_empty && !flush &&
                            (pending < (OCC_W+1)'(BUF_DEPTH));
  assign bus.m_valid      = (occupancy != '0);

  assign push = inflight_q && !drop_next_q && !flush;
  assign pop  = bus.m_valid && bus.m_ready && !flush;

  always_comb begin
    inflight_d  = bus.fifo_read_en;
    drop_next_d = drop_next_q;
    // An arrival during flush dies with the buffer clear; drop_next covers any strobe still outstanding after it.
    if (flush)                           drop_next_d = inflight_d;
    else if (inflight_q && drop_next_q)  drop_next_d = 1'b0;
    level_sum = {1'b0, fifo_level} + (ADDR_W+1)'(occupancy);
    level_d   = level_sum[ADDR_W] ? '1 : level_sum[ADDR_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q  <= 1'b0;
      drop_next_q <= 1'b0;
      level_q     <= '0;
    end else begin
      inflight_q  <= inflight_d;
      drop_next_q <= drop_next_d;
      level_q     <= level_d;
    end
  end

  assign fifo_level_o = level_q;

  iob_fifo_stream_reader_buf #(
    .DATA_W   (DATA_W),
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (push),
    .push_data(bus.fifo_data),
    .pop      (pop),
    .occupancy(occupancy),
    .head_data(bus.m_data)
  );

endmodule

// File: tb/tb_iob_fifo_stream_reader.sv
// Randomized bench for iob_fifo_stream_reader against a queue-based model of the FIFO and stream.
module tb_iob_fifo_stream_reader;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int BUF_DEPTH = 3;
  localparam int LVL_MAX   = (1 << ADDR_W) - 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                avail;   // first cycle the word may be seen on the stream
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] fifo_level = '0;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] fifo_level_o;

  iob_fifo_stream_reader_if #(.DATA_W(DATA_W)) bus ();

  iob_fifo_stream_reader #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fifo_level  (fifo_level),
    .bus         (bus),
    .occupancy   (occupancy),
    .fifo_level_o(fifo_level_o)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] fifo_q[$];   // words still inside the source FIFO
  ent_t              q_exp[$];    // words strobed and not yet consumed or discarded
  logic [DATA_W-1:0] pop_d[$];
  int                pop_c[$];
  int  n_tests = 0, n_fail = 0;
  int  cyc = 0, lvl_exp = 0, n_reads = 0, first_rd = -1, first_val = -1;
  bit  hold_empty = 1'b1;
  logic [DATA_W-1:0] next_word = 8'h40;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int sat(input int x);
    return (x > LVL_MAX) ? LVL_MAX : x;
  endfunction

  task automatic clear_logs();
    pop_d.delete();
    pop_c.delete();
    n_reads   = 0;
    first_rd  = -1;
    first_val = -1;
  endtask

  task automatic preload(input logic [DATA_W-1:0] base);
    for (int i = 0; i < 8; i++) fifo_q.push_back(base + DATA_W'(i));
  endtask

  // One clock cycle, entered and left on the falling edge.
  task automatic tick();
    int                occ_m;
    bit                rd_exp, v_exp;
    logic [DATA_W-1:0] w;
    if (rst) q_exp.delete();
    bus.fifo_empty = hold_empty || (fifo_q.size() == 0);
    #1;
    occ_m = 0;
    foreach (q_exp[i]) if (q_exp[i].avail <= cyc) occ_m++;
    v_exp  = (occ_m != 0);
    rd_exp = !rst && !bus.fifo_empty && !flush && (q_exp.size() < BUF_DEPTH);
    chk("read_en", 32'(bus.fifo_read_en), 32'(rd_exp));
    chk("m_valid", 32'(bus.m_valid), 32'(v_exp));
    chk("occupancy", 32'(occupancy), 32'(occ_m));
    chk("occ_bound", 32'(occupancy <= 3'(BUF_DEPTH)), 32'd1);
    chk("level_o", 32'(fifo_level_o), rst ? 32'd0 : 32'(lvl_exp));
    if (rst)        chk("rst_m_data", 32'(bus.m_data), 32'd0);
    else if (v_exp) chk("m_data", 32'(bus.m_data), 32'(q_exp[0].data));
    lvl_exp = rst ? 0 : sat(int'(fifo_level) + occ_m);
    if (bus.m_valid && first_val < 0) first_val = cyc;
    if (!rst && flush) begin
      q_exp.delete();
    end else if (!rst && v_exp && bus.m_ready) begin
      pop_d.push_back(bus.m_data);
      pop_c.push_back(cyc);
      $display("[TB] cyc %0d pop %02h", cyc, bus.m_data);
      void'(q_exp.pop_front());
    end
    w = DATA_W'($urandom);
    if (bus.fifo_read_en && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      q_exp.push_back('{data: w, avail: cyc + 2});
      n_reads++;
      if (first_rd < 0) first_rd = cyc;
    end
    @(posedge clk);
    #1;
    bus.fifo_data = w;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int r0;
    bus.m_ready    = 1'b0;
    bus.fifo_data  = '0;
    bus.fifo_empty = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    repeat (2) tick();

    // Continuous drain of eight words.
    rst = 1'b0; hold_empty = 1'b0; bus.m_ready = 1'b1;
    clear_logs();
    preload(8'h01);
    repeat (14) tick();
    chk("s1_reads", n_reads, 8);
    chk("s1_npop", pop_d.size(), 8);
    for (int i = 0; i < pop_d.size(); i++) chk("s1_seq", 32'(pop_d[i]), i + 1);
    if (pop_c.size() == 8) chk("s1_gapless", pop_c[7] - pop_c[0], 7);
    chk("s1_latency", first_val - first_rd, 2);

    // Stalled consumer, then level saturation and sum, then drain.
    clear_logs();
    bus.m_ready = 1'b0;
    preload(8'h01);
    repeat (6) tick();
    chk("s2_reads", n_reads, 3);
    chk("s2_occ", 32'(occupancy), 3);
    chk("s2_head", 32'(bus.m_data), 8'h01);
    fifo_level = 4'd14;
    tick();
    chk("s2_level_sat", 32'(fifo_level_o), 15);
    hold_empty = 1'b1; bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0; fifo_level = 4'd5;
    tick();
    chk("s2_level_sum", 32'(fifo_level_o), 7);
    hold_empty = 1'b0; bus.m_ready = 1'b1; fifo_level = '0;
    repeat (12) tick();
    chk("s2_npop", pop_d.size(), 8);
    for (int i = 0; i < pop_d.size(); i++) chk("s2_seq", 32'(pop_d[i]), i + 1);
    if (pop_c.size() == 8) chk("s2_gapless", pop_c[7] - pop_c[1], 6);

    // Flush with two words buffered and one in flight.
    clear_logs();
    bus.m_ready = 1'b0;
    preload(8'h11);
    repeat (3) tick();
    chk("s3_occ_pre", 32'(occupancy), 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("s3_valid_post", 32'(bus.m_valid), 0);
    chk("s3_occ_post", 32'(occupancy), 0);
    bus.m_ready = 1'b1;
    repeat (10) tick();
    if (pop_d.size() > 0) chk("s3_first", 32'(pop_d[0]), 8'h14);
    chk("s3_npop", pop_d.size(), 5);

    // Asynchronous reset mid-stream.
    clear_logs();
    bus.m_ready = 1'b0;
    preload(8'h21);
    repeat (3) tick();
    chk("s4_occ_pre", 32'(occupancy), 2);
    rst = 1'b1;
    tick();
    chk("s4_rst_occ", 32'(occupancy), 0);
    chk("s4_rst_valid", 32'(bus.m_valid), 0);
    chk("s4_rst_level", 32'(fifo_level_o), 0);
    rst = 1'b0;
    r0 = n_reads;
    tick();
    chk("s4_resume", n_reads - r0, 1);
    bus.m_ready = 1'b1;
    repeat (10) tick();
    if (pop_d.size() > 0) chk("s4_first", 32'(pop_d[0]), 8'h24);

    // Random: toggling empty, random ready, occasional flush, random level.
    clear_logs();
    for (int i = 0; i < 400; i++) begin
      hold_empty  = cyc[0];
      bus.m_ready = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 31) == 0);
      fifo_level  = ADDR_W'($urandom_range(0, LVL_MAX));
      if (fifo_q.size() < 4) begin
        fifo_q.push_back(next_word);
        next_word = next_word + 1'b1;
      end
      tick();
    end
    flush = 1'b0; hold_empty = 1'b0; bus.m_ready = 1'b1;
    repeat (12) tick();
    chk("s5_traffic", 32'(pop_d.size() > 50), 1);
    chk("s5_drained_occ", 32'(occupancy), 0);
    chk("s5_drained_valid", 32'(bus.m_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
